gpr_port_arbiter: RTL
=====================

# gpr_port_arbiter

Shares the register file's two read ports and single write port between two requesters: requester 0 is the main pipeline and requester 1 is the debug/exception unit. The block arbitrates each port class round-robin. It drives the register file address and write controls, and returns read data one cycle after grant, tagged with the requester id. The register file samples read data on the clock edge and returns the old value on a same-cycle read/write to the same address, so this block bypasses the granted write data in that case.

## Interface
- No parameters: data 32 bits, register address 5 bits, 2 requesters; all fixed.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rq0_valid, rq1_valid  in  1  read request
- rq0_a1, rq0_a2, rq1_a1, rq1_a2  in  5  read addresses
- rq0_ready, rq1_ready  out  1  read grant; the request is accepted this cycle
- rsp_valid  out  1  read response valid
- rsp_id  out  1  requester of the response
- rsp_d1, rsp_d2  out  32  read data for a1/a2
- wq0_valid, wq1_valid  in  1  write request
- wq0_addr, wq1_addr  in  5  write address
- wq0_data, wq1_data  in  32  write data
- wq0_ready, wq1_ready  out  1  write grant
- gpr_a1, gpr_a2  out  5  register file read addresses
- gpr_a3  out  5  register file write address
- gpr_wdata  out  32  register file write data
- gpr_we  out  1  register file write enable
- gpr_rd1, gpr_rd2  in  32  register file read data (registered, 1-cycle latency)

## Operation
- Read and write arbitration are independent. Each cycle allows at most one read grant and one write grant.
- Round-robin per port class uses 1-bit pointers rd_last and wr_last, each holding the id of the last grant.
  - Only one requester valid: grant it.
  - Both valid: grant the requester != *_last.
  - The pointer updates only on a grant.
- ready is combinational from the valids and the pointer. A requester holds valid and its addresses/data stable until ready. An accepted request may be withdrawn afterwards.
- Read-port mux: gpr_a1/gpr_a2 = granted requester's addresses. With no read grant, they are the requester-0 addresses (don't care).
- Write-port mux: gpr_a3/gpr_wdata = granted requester's fields. gpr_we = any write grant.
- A write to address 0 is granted normally. The register file drops it, and no bypass applies.
- Response register (captured on the grant edge):
  - rsp_valid = read grant.
  - rsp_id = granted id.
  - byp1 = (write granted) & (gpr_a3 == gpr_a1) & (gpr_a1 != 0). byp2 is the same check against gpr_a2.
  - bdata = gpr_wdata.
- Response data: rsp_d1 = byp1 ? bdata : gpr_rd1, and rsp_d2 likewise.
  - Both read addresses may bypass simultaneously.
- No response backpressure: the consumer must accept rsp in the cycle rsp_valid is high.

## Timing
- Reset values:
  - rsp_valid=0, rsp_id=0, byp1=byp2=0, bdata=0.
  - rd_last=wr_last=1, so requester 0 wins the first contention.
  - Because ready/gpr_we are combinational from inputs, requesters must hold valid low while rst is asserted.
- Read latency: grant in cycle N, then rsp_valid and data in cycle N+1. Back-to-back grants give a response every cycle.
- Write latency: grant in cycle N updates the register at the end of cycle N. A read granted in N+1 or later sees the new value without bypass.
- Same-cycle read and write to the same nonzero address: the response carries the new write data.
- Write granted in the response cycle N+1: no effect on that response.
- Reset asserted mid-operation: the pending response is discarded (rsp_valid forced 0 asynchronously) and the pointers are restored.
- Alternating contention: with both valid every cycle, grants go 0,1,0,1…. A requester never waits more than 1 cycle behind the other.

## Test plan
- Reset, then rq0 reads a1=3, a2=0 after wq0 wrote r3=0x12345678 the previous cycle → cycle N+1: rsp_valid=1, rsp_id=0, rsp_d1=0x12345678, rsp_d2=0.
- Same cycle: rq1 reads a1=5, a2=5 and wq0 writes r5=0xDEADBEEF (r5 was 0) → rsp_id=1, rsp_d1=rsp_d2=0xDEADBEEF.
- Same cycle: wq1 writes r0=0xFFFFFFFF and rq0 reads a1=0 → rsp_d1=0, no bypass. A later read of r0 also returns 0.
- Both rq0 and rq1 valid for 4 cycles from reset → grants 0,1,0,1. rsp_id sequence 0,1,0,1 one cycle later. Same check for wq0/wq1 with gpr_we high all 4 cycles.
- rq1 alone valid for 3 cycles, then both valid → the first contended grant goes to 0.
- Assert rst in the cycle after a read grant → rsp_valid drops immediately and no response appears after rst deasserts. The first contention after reset is granted to requester 0.

Source files
------------

// File: rtl/gpr_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// gpr_port_arbiter_if
// Bundles the requester, response and register-file signals of the GPR port
// arbiter.
//   slave  modport : the arbiter itself
//   master modport : the environment (pipeline, debug unit, register file)
// Signal groups:
//   rq0_*/rq1_*  read requests (valid, a1, a2) and read grants (ready)
//   rsp_*        read response (valid, id, d1, d2), one cycle after grant
//   wq0_*/wq1_*  write requests (valid, addr, data) and write grants (ready)
//   gpr_*        register file read/write port controls and read data
// ---------------------------------------------------------------------------
interface gpr_port_arbiter_if;
    // read requests
    logic        rq0_valid;
    logic        rq1_valid;
    logic [4:0]  rq0_a1;
    logic [4:0]  rq0_a2;
    logic [4:0]  rq1_a1;
    logic [4:0]  rq1_a2;
    logic        rq0_ready;
    logic        rq1_ready;
    // read response
    logic        rsp_valid;
    logic        rsp_id;
    logic [31:0] rsp_d1;
    logic [31:0] rsp_d2;
    // write requests
    logic        wq0_valid;
    logic        wq1_valid;
    logic [4:0]  wq0_addr;
    logic [4:0]  wq1_addr;
    logic [31:0] wq0_data;
    logic [31:0] wq1_data;
    logic        wq0_ready;
    logic        wq1_ready;
    // register file port
    logic [4:0]  gpr_a1;
    logic [4:0]  gpr_a2;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wdata;
    logic        gpr_we;
    logic [31:0] gpr_rd1;
    logic [31:0] gpr_rd2;

    modport slave (
        input  rq0_valid, rq1_valid, rq0_a1, rq0_a2, rq1_a1, rq1_a2,
        output rq0_ready, rq1_ready,
        output rsp_valid, rsp_id, rsp_d1, rsp_d2,
        input  wq0_valid, wq1_valid, wq0_addr, wq1_addr, wq0_data, wq1_data,
        output wq0_ready, wq1_ready,
        output gpr_a1, gpr_a2, gpr_a3, gpr_wdata, gpr_we,
        input  gpr_rd1, gpr_rd2
    );

    modport master (
        output rq0_valid, rq1_valid, rq0_a1, rq0_a2, rq1_a1, rq1_a2,
        input  rq0_ready, rq1_ready,
        input  rsp_valid, rsp_id, rsp_d1, rsp_d2,
        output wq0_valid, wq1_valid, wq0_addr, wq1_addr, wq0_data, wq1_data,
        input  wq0_ready, wq1_ready,
        input  gpr_a1, gpr_a2, gpr_a3, gpr_wdata, gpr_we,
        output gpr_rd1, gpr_rd2
    );
endinterface

// File: rtl/gpr_port_arbiter.sv
// ---------------------------------------------------------------------------
// gpr_port_arbiter
// Shares the register file's two read ports and one write port between the
// main pipeline (requester 0) and the debug/exception unit (requester 1).
// Reads and writes are arbitrated independently, each round-robin with a
// 1-bit "last granted" pointer. Read data returns one cycle after grant,
// tagged with the requester id; a write granted in the same cycle to the same
// nonzero address is bypassed into the response because the register file
// returns the old value in that case.
// Ports:
//   clk  clock
//   rst  asynchronous, active-high reset
//   bus  gpr_port_arbiter_if.slave (requests, grants, response, GPR port)
// ---------------------------------------------------------------------------
module gpr_port_arbiter (
    input  logic              clk,
    input  logic              rst,
    gpr_port_arbiter_if.slave bus
);
    localparam int NPORT = 2;   // read ports a1/a2

    // Two-requester round-robin: a lone requester always wins; under
    // contention the one that was not granted last wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] req, input logic last);
        logic [1:0] gnt;
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        return gnt;
    endfunction

    logic [1:0]       w_rd_req;
    logic [1:0]       w_wr_req;
    logic [1:0]       w_rd_gnt;
    logic [1:0]       w_wr_gnt;
    logic             w_rd_any;
    logic             w_wr_any;
    logic             w_rd_id;
    logic             w_wr_id;
    logic [4:0]       w_rd_addr [NPORT];
    logic [31:0]      w_rf_rd   [NPORT];
    logic [31:0]      w_rsp_d   [NPORT];
    logic [NPORT-1:0] w_byp;
    logic [4:0]       w_a3;
    logic [31:0]      w_wdata;

    logic             r_rd_last;
    logic             r_wr_last;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [NPORT-1:0] r_byp;
    logic [31:0]      r_bdata;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_rd_req = {bus.rq1_valid, bus.rq0_valid};
    assign w_wr_req = {bus.wq1_valid, bus.wq0_valid};
    assign w_rd_gnt = rr_grant(w_rd_req, r_rd_last);
    assign w_wr_gnt = rr_grant(w_wr_req, r_wr_last);

    assign w_rd_any = |w_rd_gnt;
    assign w_wr_any = |w_wr_gnt;
    assign w_rd_id  = w_rd_gnt[1];
    assign w_wr_id  = w_wr_gnt[1];

    assign bus.rq0_ready = w_rd_gnt[0];
    assign bus.rq1_ready = w_rd_gnt[1];
    assign bus.wq0_ready = w_wr_gnt[0];
    assign bus.wq1_ready = w_wr_gnt[1];

    // ------------------------------------------------------------------
    // Port muxes (requester 0 fields when nothing is granted)
    // ------------------------------------------------------------------
    assign w_rd_addr[0] = w_rd_gnt[1] ? bus.rq1_a1 : bus.rq0_a1;
    assign w_rd_addr[1] = w_rd_gnt[1] ? bus.rq1_a2 : bus.rq0_a2;
    assign w_a3         = w_wr_gnt[1] ? bus.wq1_addr : bus.wq0_addr;
    assign w_wdata      = w_wr_gnt[1] ? bus.wq1_data : bus.wq0_data;

    assign bus.gpr_a1    = w_rd_addr[0];
    assign bus.gpr_a2    = w_rd_addr[1];
    assign bus.gpr_a3    = w_a3;
    assign bus.gpr_wdata = w_wdata;
    assign bus.gpr_we    = w_wr_any;

    assign w_rf_rd[0] = bus.gpr_rd1;
    assign w_rf_rd[1] = bus.gpr_rd2;

    // ------------------------------------------------------------------
    // Same-cycle read/write bypass, one per read port. Address 0 is never
    // bypassed: the register file drops writes to it and reads return 0.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            assign w_byp[gi]   = w_wr_any && (w_a3 == w_rd_addr[gi]) && (w_rd_addr[gi] != 5'd0);
            assign w_rsp_d[gi] = r_byp[gi] ? r_bdata : w_rf_rd[gi];
        end
    endgenerate

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_d1    = w_rsp_d[0];
    assign bus.rsp_d2    = w_rsp_d[1];

    // ------------------------------------------------------------------
    // Pointers and response register. Pointers reset to 1 so requester 0
    // wins the first contention after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_last   <= 1'b1;
            r_wr_last   <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_byp       <= '0;
            r_bdata     <= '0;
        end else begin
            if (w_rd_any) begin
                r_rd_last <= w_rd_id;
            end
            if (w_wr_any) begin
                r_wr_last <= w_wr_id;
            end
            r_rsp_valid <= w_rd_any;
            r_rsp_id    <= w_rd_id;
            // bypass flags only matter for a cycle that carries a response
            r_byp       <= w_byp & {NPORT{w_rd_any}};
            r_bdata     <= w_wdata;
        end
    end
endmodule
